vector_unpack: RTL and testbench

//  Width-converting gearbox: takes packed IN_W-bit words and emits them as a stream of
//  OUT_W-bit fields, including fields that straddle word boundaries.

---
 rtl/vector_unpack.sv | 128 ++++++++++++
 tb/tb_vector_unpack.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/vector_unpack.sv
// Width-converting gearbox: packed IN_W-bit words in, OUT_W-bit fields out, with a zero-padded flush at packet end.
// Define VECTOR_UNPACK_MSB_FIRST_EN to take fields from the MSB end of each word (default: LSB-first).
module vector_unpack #(
    parameter int IN_W  = 32,
    parameter int OUT_W = 7
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [IN_W-1:0]        in_data,
    input  logic                   in_last,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [OUT_W-1:0]       out_data,
    output logic                   out_last,
    output logic [$clog2(OUT_W):0] out_pad
);

    localparam int W  = IN_W + OUT_W;
    localparam int CW = $clog2(W + 1);
    localparam int PW = $clog2(OUT_W) + 1;

    localparam logic [CW-1:0] IN_W_C  = CW'(IN_W);
    localparam logic [CW-1:0] OUT_W_C = CW'(OUT_W);

    generate
        if (OUT_W < 1 || IN_W < OUT_W) begin : g_bad_widths
            $error("vector_unpack: requires IN_W >= OUT_W >= 1");
        end
    endgenerate

    typedef enum logic {
        RUN   = 1'b0,
        FLUSH = 1'b1
    } state_t;

    state_t         state_q, state_d;
    logic [W-1:0]   resid_q, resid_d;
    logic [CW-1:0]  cnt_q, cnt_d;

    logic [W-1:0]     word_ins;
    logic [W-1:0]     resid_shift;
    logic [OUT_W-1:0] field;
    logic [OUT_W-1:0] field_mask;
    logic             final_fld;

`ifdef VECTOR_UNPACK_MSB_FIRST_EN
    // Valid residue occupies the top cnt bits; a new word lands directly beneath it.
    assign field       = resid_q[W-1 -: OUT_W];
    assign resid_shift = resid_q << OUT_W;
    assign word_ins    = {in_data, {OUT_W{1'b0}}} >> cnt_q;
    assign field_mask  = {OUT_W{1'b1}} << (OUT_W_C - cnt_q);
`else
    // Valid residue occupies the bottom cnt bits; a new word lands directly above it.
    assign field       = resid_q[OUT_W-1:0];
    assign resid_shift = resid_q >> OUT_W;
    assign word_ins    = {{OUT_W{1'b0}}, in_data} << cnt_q;
    assign field_mask  = ~({OUT_W{1'b1}} << cnt_q);
`endif

    assign final_fld = (cnt_q <= OUT_W_C);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= RUN;
            resid_q <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            resid_q <= resid_d;
            cnt_q   <= cnt_d;
        end
    end

    // Handshake outputs depend only on registered state, never on out_ready or in_valid.
    always_comb begin
        state_d   = state_q;
        resid_d   = resid_q;
        cnt_d     = cnt_q;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        out_data  = field;
        out_last  = 1'b0;
        out_pad   = '0;

        case (state_q)
            RUN: begin
                in_ready  = (cnt_q < OUT_W_C);
                out_valid = (cnt_q >= OUT_W_C);
                if (in_valid && in_ready) begin
                    resid_d = resid_q | word_ins;
                    cnt_d   = cnt_q + IN_W_C;
                    if (in_last) begin
                        state_d = FLUSH;
                    end
                end else if (out_valid && out_ready) begin
                    resid_d = resid_shift;
                    cnt_d   = cnt_q - OUT_W_C;
                end
            end

            FLUSH: begin
                out_valid = (cnt_q != '0);
                if (final_fld) begin
                    out_last = 1'b1;
                    out_pad  = PW'(OUT_W_C - cnt_q);
                    out_data = field & field_mask;
                end
                if (out_valid && out_ready) begin
                    if (final_fld) begin
                        resid_d = '0;
                        cnt_d   = '0;
                        state_d = RUN;
                    end else begin
                        resid_d = resid_shift;
                        cnt_d   = cnt_q - OUT_W_C;
                    end
                end
            end

            default: begin
                state_d = RUN;
            end
        endcase
    end

endmodule

// File: tb/tb_vector_unpack.sv
// Directed self-checking bench for vector_unpack at IN_W=32, OUT_W=7.
// With VECTOR_UNPACK_MSB_FIRST_EN defined it runs the MSB-first sequence instead.
module tb_vector_unpack;

    localparam int IN_W  = 32;
    localparam int OUT_W = 7;

    logic                   clk = 1'b0;
    logic                   rst_n;
    logic                   in_valid;
    logic                   in_ready;
    logic [IN_W-1:0]        in_data;
    logic                   in_last;
    logic                   out_valid;
    logic                   out_ready;
    logic [OUT_W-1:0]       out_data;
    logic                   out_last;
    logic [$clog2(OUT_W):0] out_pad;

    int tests = 0;
    int fails = 0;

    vector_unpack #(.IN_W(IN_W), .OUT_W(OUT_W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_last   (in_last),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_last  (out_last),
        .out_pad   (out_pad)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_word(input string tag, input logic [31:0] data, input logic last);
        check({tag, ".in_ready"}, 32'(in_ready), 32'd1);
        in_valid = 1'b1;
        in_data  = data;
        in_last  = last;
        tick();
        in_valid = 1'b0;
        in_last  = 1'b0;
        in_data  = '0;
    endtask

    task automatic expect_field(input string tag, input logic [31:0] data,
                                input logic [31:0] last, input logic [31:0] pad);
        check({tag, ".valid"}, 32'(out_valid), 32'd1);
        check({tag, ".data"}, 32'(out_data), data);
        check({tag, ".last"}, 32'(out_last), last);
        check({tag, ".pad"}, 32'(out_pad), pad);
        check({tag, ".in_ready"}, 32'(in_ready), 32'd0);
        out_ready = 1'b1;
        tick();
    endtask

    task automatic expect_idle(input string tag);
        check({tag, ".valid"}, 32'(out_valid), 32'd0);
        check({tag, ".in_ready"}, 32'(in_ready), 32'd1);
        check({tag, ".last"}, 32'(out_last), 32'd0);
    endtask

    task automatic drain(input string tag);
        int guard;
        guard = 0;
        out_ready = 1'b1;
        while (out_valid && guard < 64) begin
            tick();
            guard++;
        end
        check({tag, ".drain_bound"}, 32'(out_valid), 32'd0);
    endtask

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        in_last   = 1'b0;
        out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("reset.in_ready", 32'(in_ready), 32'd1);
        check("reset.out_valid", 32'(out_valid), 32'd0);
        check("reset.out_data", 32'(out_data), 32'd0);
        check("reset.out_last", 32'(out_last), 32'd0);
        check("reset.out_pad", 32'(out_pad), 32'd0);
        #2 rst_n = 1'b1;
        tick();

`ifdef VECTOR_UNPACK_MSB_FIRST_EN
        send_word("msb.w0", 32'h76543210, 1'b1);
        expect_field("msb.f0", 32'h3B, 0, 0);
        expect_field("msb.f1", 32'h15, 0, 0);
        expect_field("msb.f2", 32'h06, 0, 0);
        expect_field("msb.f3", 32'h21, 0, 0);
        expect_field("msb.f4", 32'h00, 1, 3);
        expect_idle("msb.end");
`else
        // Single-word packet: four full fields, then 4-bit residue padded by 3.
        send_word("t1.w0", 32'h76543210, 1'b1);
        expect_field("t1.f0", 32'h10, 0, 0);
        expect_field("t1.f1", 32'h64, 0, 0);
        expect_field("t1.f2", 32'h50, 0, 0);
        expect_field("t1.f3", 32'h32, 0, 0);
        expect_field("t1.f4", 32'h07, 1, 3);
        expect_idle("t1.end");

        // Field straddling a word boundary, then a flush leaving 5 bits (pad 2).
        send_word("t2.w0", 32'h76543210, 1'b0);
        expect_field("t2.f0", 32'h10, 0, 0);
        expect_field("t2.f1", 32'h64, 0, 0);
        expect_field("t2.f2", 32'h50, 0, 0);
        expect_field("t2.f3", 32'h32, 0, 0);
        expect_idle("t2.resid4");
        send_word("t2.w1", 32'hFFFFFFFF, 1'b0);
        expect_field("t2.f4", 32'h77, 0, 0);
        for (int i = 0; i < 4; i++) expect_field("t2.ones", 32'h7F, 0, 0);
        expect_idle("t2.resid1");
        send_word("t2.w2", 32'h00000000, 1'b1);
        expect_field("t2.f9", 32'h01, 0, 0);
        for (int i = 0; i < 3; i++) expect_field("t2.zeros", 32'h00, 0, 0);
        expect_field("t2.fin", 32'h00, 1, 2);
        expect_idle("t2.end");

        // Backpressure on the second field holds everything stable.
        send_word("t3.w0", 32'h76543210, 1'b1);
        expect_field("t3.f0", 32'h10, 0, 0);
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            check("t3.hold.valid", 32'(out_valid), 32'd1);
            check("t3.hold.data", 32'(out_data), 32'h64);
            check("t3.hold.in_ready", 32'(in_ready), 32'd0);
            tick();
        end
        expect_field("t3.f1", 32'h64, 0, 0);
        expect_field("t3.f2", 32'h50, 0, 0);
        expect_field("t3.f3", 32'h32, 0, 0);
        expect_field("t3.f4", 32'h07, 1, 3);
        expect_idle("t3.end");

        // Six zero words leave residue 3; a final all-ones word then ends on an exact field.
        for (int w = 0; w < 6; w++) begin
            send_word("t4.pre", 32'h00000000, 1'b0);
            drain("t4.pre");
        end
        send_word("t4.wl", 32'hFFFFFFFF, 1'b1);
        expect_field("t4.f0", 32'h78, 0, 0);
        for (int i = 0; i < 3; i++) expect_field("t4.mid", 32'h7F, 0, 0);
        expect_field("t4.fin", 32'h7F, 1, 0);
        expect_idle("t4.end");

        // Asynchronous reset mid-packet discards the residue at once.
        send_word("t5.w0", 32'h76543210, 1'b1);
        expect_field("t5.f0", 32'h10, 0, 0);
        expect_field("t5.f1", 32'h64, 0, 0);
        rst_n = 1'b0;
        #1;
        check("t5.rst.out_valid", 32'(out_valid), 32'd0);
        check("t5.rst.in_ready", 32'(in_ready), 32'd1);
        check("t5.rst.out_data", 32'(out_data), 32'd0);
        check("t5.rst.out_last", 32'(out_last), 32'd0);
        #2 rst_n = 1'b1;
        tick();
        expect_idle("t5.after");
        send_word("t5.w1", 32'h00000001, 1'b0);
        expect_field("t5.f2", 32'h01, 0, 0);
        for (int i = 0; i < 3; i++) expect_field("t5.zeros", 32'h00, 0, 0);
        expect_idle("t5.end");
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
